// File: rtl/ov5640_cfg_pkg.sv
// Shared constants for the OV5640 SCCB configuration sequencer:
// I2C master register map, command bits, LUT marker and FSM states.
package ov5640_cfg_pkg;

  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXR    = 3'd3;
  localparam logic [2:0] REG_CR     = 3'd4;

  localparam logic [7:0] CR_STA     = 8'h80;
  localparam logic [7:0] CR_STO     = 8'h40;
  localparam logic [7:0] CR_WR      = 8'h10;
  localparam logic [7:0] CR_IACK    = 8'h01;
  localparam logic [7:0] CTR_EN_IEN = 8'hC0;

  localparam logic [31:0] LUT_END = 32'hFFFF_FFFF;

  typedef logic [3:0] state_t;

  localparam state_t S_PWRUP    = 4'd0;
  localparam state_t S_INIT     = 4'd1;
  localparam state_t S_LOAD     = 4'd2;
  localparam state_t S_TXR      = 4'd3;
  localparam state_t S_CR       = 4'd4;
  localparam state_t S_WAIT_INT = 4'd5;
  localparam state_t S_IACK     = 4'd6;
  localparam state_t S_WAIT_CLR = 4'd7;
  localparam state_t S_NEXT     = 4'd8;
  localparam state_t S_DELAY    = 4'd9;
  localparam state_t S_DONE     = 4'd10;
  localparam state_t S_ERROR    = 4'd11;

  function automatic logic [7:0] tx_byte(
    input logic [31:0] e,
    input logic [1:0]  b
  );
    logic [7:0] v;
    unique case (b)
      2'd0:    v = e[31:24];
      2'd1:    v = e[23:16];
      2'd2:    v = e[15:8];
      default: v = e[7:0];
    endcase
    return v;
  endfunction

  function automatic logic [7:0] cr_cmd(input logic [1:0] b);
    logic [7:0] c;
    unique case (1'b1)
      b == 2'd0: c = CR_STA | CR_WR;
      b == 2'd3: c = CR_STO | CR_WR;
      default:   c = CR_WR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov5640_i2c_sequencer.sv
// Walks the OV5640 register LUT and drives the I2C master register
// interface with one four-byte SCCB write per entry.
module ov5640_i2c_sequencer
  import ov5640_cfg_pkg::*;
#(
  parameter logic [9:0]  LUT_SIZE     = 10'd256,
  parameter logic [15:0] PRESCALE     = 16'd53,
  parameter int unsigned PWRUP_WAIT   = 540_000,
  parameter int unsigned SWRST_WAIT   = 135_000,
  parameter int unsigned BYTE_TIMEOUT = 27_000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  output logic [9:0]  O_lut_index,
  input  logic [31:0] I_lut_data,
  output logic        O_tx_en,
  output logic [2:0]  O_waddr,
  output logic [7:0]  O_wdata,
  input  logic        I_iic_int,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err
);

  localparam logic [19:0] PW_LAST = 20'(PWRUP_WAIT - 1);
  localparam logic [19:0] SW_LAST = 20'(SWRST_WAIT - 1);
  localparam logic [19:0] TO_LAST = 20'(BYTE_TIMEOUT - 1);

  state_t      state, nstate;
  logic [1:0]  b, nb;
  logic [19:0] wait_cnt, ncnt;
  logic [31:0] ent, nent;
  logic [9:0]  nidx;
  logic        stb;
  logic [2:0]  saddr;
  logic [7:0]  sdata;
  logic        ndone, nerr;

  // Strobe outputs are computed with the next state so the
  // registered strobe coincides with the state that issues it.
  always_comb begin
    nstate = state;
    nb     = b;
    ncnt   = wait_cnt;
    nent   = ent;
    nidx   = O_lut_index;
    stb    = 1'b0;
    saddr  = O_waddr;
    sdata  = O_wdata;
    ndone  = O_done;
    nerr   = O_err;
    unique case (state)
      S_PWRUP: begin
        if (wait_cnt == PW_LAST) begin
          nstate = S_INIT;
          nb     = 2'd0;
          ncnt   = '0;
          stb    = 1'b1;
          saddr  = REG_PRERLO;
          sdata  = PRESCALE[7:0];
        end else begin
          ncnt = wait_cnt + 20'd1;
        end
      end
      S_INIT: begin
        unique case (b)
          2'd0: begin
            nb    = 2'd1;
            stb   = 1'b1;
            saddr = REG_PRERHI;
            sdata = PRESCALE[15:8];
          end
          2'd1: begin
            nb    = 2'd2;
            stb   = 1'b1;
            saddr = REG_CTR;
            sdata = CTR_EN_IEN;
          end
          default: begin
            nstate = S_LOAD;
            nb     = 2'd0;
          end
        endcase
      end
      S_LOAD: begin
        if (O_lut_index == LUT_SIZE || I_lut_data == LUT_END) begin
          nstate = S_DONE;
          ndone  = 1'b1;
        end else begin
          nent   = I_lut_data;
          nb     = 2'd0;
          nstate = S_TXR;
          stb    = 1'b1;
          saddr  = REG_TXR;
          sdata  = tx_byte(I_lut_data, 2'd0);
        end
      end
      S_TXR: begin
        nstate = S_CR;
        stb    = 1'b1;
        saddr  = REG_CR;
        sdata  = cr_cmd(b);
      end
      S_CR: begin
        nstate = S_WAIT_INT;
        ncnt   = '0;
      end
      S_WAIT_INT: begin
        if (I_iic_int) begin
          nstate = S_IACK;
          stb    = 1'b1;
          saddr  = REG_CR;
          sdata  = CR_IACK;
        end else if (wait_cnt == TO_LAST) begin
          nstate = S_ERROR;
          nerr   = 1'b1;
        end else begin
          ncnt = wait_cnt + 20'd1;
        end
      end
      S_IACK: nstate = S_WAIT_CLR;
      S_WAIT_CLR: begin
        if (!I_iic_int) begin
          if (b == 2'd3) begin
            nstate = S_NEXT;
          end else begin
            nb     = b + 2'd1;
            nstate = S_TXR;
            stb    = 1'b1;
            saddr  = REG_TXR;
            sdata  = tx_byte(ent, b + 2'd1);
          end
        end
      end
      S_NEXT: begin
        nidx = O_lut_index + 10'd1;
        // A software reset of the sensor needs settling time.
        if (ent[23:8] == 16'h3008 && ent[7]) begin
          nstate = S_DELAY;
          ncnt   = '0;
        end else begin
          nstate = S_LOAD;
        end
      end
      S_DELAY: begin
        if (wait_cnt == SW_LAST) nstate = S_LOAD;
        else ncnt = wait_cnt + 20'd1;
      end
      S_DONE:  nstate = S_DONE;
      S_ERROR: nstate = S_ERROR;
      default: nstate = S_PWRUP;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= S_PWRUP;
      b           <= '0;
      wait_cnt    <= '0;
      ent         <= '0;
      O_lut_index <= '0;
      O_tx_en     <= 1'b0;
      O_waddr     <= '0;
      O_wdata     <= '0;
      O_busy      <= 1'b1;
      O_done      <= 1'b0;
      O_err       <= 1'b0;
    end else begin
      state       <= nstate;
      b           <= nb;
      wait_cnt    <= ncnt;
      ent         <= nent;
      O_lut_index <= nidx;
      O_tx_en     <= stb;
      O_waddr     <= saddr;
      O_wdata     <= sdata;
      O_busy      <= ~(ndone | nerr);
      O_done      <= ndone;
      O_err       <= nerr;
    end
  end

endmodule
